seg_capture: RTL and testbench

- Reader side of the seven-segment display path. It samples multiplexed, active-low segment and digit-select lines and recovers the 4-bit hex value of each digit.
- A value is accepted only after the pattern has been stable for a set number of samples, which filters out scan ghosting.
- Used by the scoreboard self-check logic and by board-level loopback to confirm what the display drivers actually show.

---
 rtl/seg_capture_pkg.sv | 36 +++
 rtl/seg_pattern_decode.sv | 41 ++++
 rtl/seg_capture.sv | 140 ++++++++++++++
 tb/tb_seg_capture.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_capture_pkg.sv
// +----------------------------------------------------------------------+
// | seg_capture_pkg : shared seven-segment glyph constants and types     |
// | Revision        : 1.0                                                |
// +----------------------------------------------------------------------+
`default_nettype none

package seg_capture_pkg;

   // Active-low glyphs, bit0 = a .. bit6 = g; the binary-to-segment encoder imports these too
   localparam logic [6:0] SEG_0     = 7'h40;
   localparam logic [6:0] SEG_1     = 7'h79;
   localparam logic [6:0] SEG_2     = 7'h24;
   localparam logic [6:0] SEG_3     = 7'h30;
   localparam logic [6:0] SEG_4     = 7'h19;
   localparam logic [6:0] SEG_5     = 7'h12;
   localparam logic [6:0] SEG_6     = 7'h02;
   localparam logic [6:0] SEG_7     = 7'h78;
   localparam logic [6:0] SEG_8     = 7'h00;
   localparam logic [6:0] SEG_9     = 7'h10;
   localparam logic [6:0] SEG_A     = 7'h08;
   localparam logic [6:0] SEG_B     = 7'h03;
   localparam logic [6:0] SEG_C     = 7'h46;
   localparam logic [6:0] SEG_D     = 7'h21;
   localparam logic [6:0] SEG_E     = 7'h06;
   localparam logic [6:0] SEG_F     = 7'h0E;
   localparam logic [6:0] SEG_BLANK = 7'h7F;

   typedef struct packed {
      logic       legal;
      logic       blank;
      logic [3:0] hex;
   } seg_decode_t;

endpackage

`default_nettype wire

// File: rtl/seg_pattern_decode.sv
// +----------------------------------------------------------------------+
// | seg_pattern_decode : 7-bit active-low pattern to {legal, blank, hex} |
// | Revision           : 1.0                                             |
// +----------------------------------------------------------------------+
`default_nettype none

module seg_pattern_decode
   import seg_capture_pkg::*;
(
   input  logic [6:0]  pat,
   output seg_decode_t dec
);

   always_comb begin
      dec.legal = 1'b1;
      dec.blank = (pat == SEG_BLANK);
      dec.hex   = 4'h0;
      case (pat)
         SEG_0:   dec.hex = 4'h0;
         SEG_1:   dec.hex = 4'h1;
         SEG_2:   dec.hex = 4'h2;
         SEG_3:   dec.hex = 4'h3;
         SEG_4:   dec.hex = 4'h4;
         SEG_5:   dec.hex = 4'h5;
         SEG_6:   dec.hex = 4'h6;
         SEG_7:   dec.hex = 4'h7;
         SEG_8:   dec.hex = 4'h8;
         SEG_9:   dec.hex = 4'h9;
         SEG_A:   dec.hex = 4'hA;
         SEG_B:   dec.hex = 4'hB;
         SEG_C:   dec.hex = 4'hC;
         SEG_D:   dec.hex = 4'hD;
         SEG_E:   dec.hex = 4'hE;
         SEG_F:   dec.hex = 4'hF;
         default: dec.legal = 1'b0;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/seg_capture.sv
// +----------------------------------------------------------------------+
// | seg_capture : recovers hex digits from multiplexed 7-seg lines,      |
// |               committing a digit only after a stable run of samples  |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
`default_nettype none

module seg_capture
   import seg_capture_pkg::*;
#(
   parameter int NUM_DIGITS   = 4,
   parameter int STABLE_COUNT = 3,
   parameter int CNT_W        = 4
)(
   input  logic                                              clk,
   input  logic                                              rst_n,
   input  logic                                              sample_en,
   input  logic [6:0]                                        seg_in,
   input  logic [NUM_DIGITS-1:0]                             digit_sel,
   input  logic                                              clear,
   output logic [4*NUM_DIGITS-1:0]                           value,
   output logic [NUM_DIGITS-1:0]                             valid,
   output logic [NUM_DIGITS-1:0]                             err,
   output logic                                              update,
   output logic [((NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1)-1:0] upd_idx,
   output logic                                              sel_err
);

   localparam int             IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [CNT_W-1:0] STABLE_CNT = CNT_W'(STABLE_COUNT);
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

   logic [4*NUM_DIGITS-1:0] value_q,   value_d;
   logic [NUM_DIGITS-1:0]   valid_q,   valid_d;
   logic [NUM_DIGITS-1:0]   err_q,     err_d;
   logic                    update_q,  update_d;
   logic [IDX_W-1:0]        upd_idx_q, upd_idx_d;
   logic                    sel_err_q, sel_err_d;
   logic [6:0]              last_pat_q [NUM_DIGITS];
   logic [6:0]              last_pat_d [NUM_DIGITS];
   logic [CNT_W-1:0]        cnt_q      [NUM_DIGITS];
   logic [CNT_W-1:0]        cnt_d      [NUM_DIGITS];

   logic        sel_ok;
   logic        commit;
   seg_decode_t seg_dec;

   // A commit always means seg_in equals the stored pattern, so decoding seg_in suffices
   seg_pattern_decode u_decode (
      .pat (seg_in),
      .dec (seg_dec)
   );

   assign sel_ok = ($countones(~digit_sel) == 1);

   always_comb begin
      value_d   = value_q;
      valid_d   = valid_q;
      err_d     = err_q;
      upd_idx_d = upd_idx_q;
      update_d  = 1'b0;
      sel_err_d = 1'b0;
      commit    = 1'b0;
      last_pat_d = last_pat_q;
      cnt_d      = cnt_q;

      if (clear) begin
         valid_d = '0;
         err_d   = '0;
         for (int i = 0; i < NUM_DIGITS; i++) begin
            last_pat_d[i] = SEG_BLANK;
            cnt_d[i]      = '0;
         end
      end else if (sample_en) begin
         if (!sel_ok) begin
            sel_err_d = 1'b1;
         end else begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
               if (!digit_sel[i]) begin
                  // Saturated hold never commits, so a steady digit commits once
                  if (seg_in != last_pat_q[i]) begin
                     last_pat_d[i] = seg_in;
                     cnt_d[i]      = CNT_ONE;
                     commit        = (STABLE_CNT == CNT_ONE);
                  end else if (cnt_q[i] < STABLE_CNT) begin
                     cnt_d[i] = cnt_q[i] + CNT_ONE;
                     commit   = ((cnt_q[i] + CNT_ONE) == STABLE_CNT);
                  end
                  if (commit) begin
                     update_d  = 1'b1;
                     upd_idx_d = IDX_W'(i);
                     if (seg_dec.legal) begin
                        value_d[4*i +: 4] = seg_dec.hex;
                        valid_d[i]        = 1'b1;
                        err_d[i]          = 1'b0;
                     end else begin
                        valid_d[i] = 1'b0;
                        err_d[i]   = !seg_dec.blank;
                     end
                  end
               end
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         value_q   <= '0;
         valid_q   <= '0;
         err_q     <= '0;
         update_q  <= 1'b0;
         upd_idx_q <= '0;
         sel_err_q <= 1'b0;
         for (int i = 0; i < NUM_DIGITS; i++) begin
            last_pat_q[i] <= SEG_BLANK;
            cnt_q[i]      <= '0;
         end
      end else begin
         value_q   <= value_d;
         valid_q   <= valid_d;
         err_q     <= err_d;
         update_q  <= update_d;
         upd_idx_q <= upd_idx_d;
         sel_err_q <= sel_err_d;
         last_pat_q <= last_pat_d;
         cnt_q      <= cnt_d;
      end
   end

   assign value   = value_q;
   assign valid   = valid_q;
   assign err     = err_q;
   assign update  = update_q;
   assign upd_idx = upd_idx_q;
   assign sel_err = sel_err_q;

endmodule

`default_nettype wire

// File: tb/tb_seg_capture.sv
// +----------------------------------------------------------------------+
// | tb_seg_capture : directed self-checking bench for seg_capture        |
// | Revision       : 1.0                                                 |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_seg_capture;

   logic        clk;
   logic        rst_n;
   logic        sample_en;
   logic [6:0]  seg_in;
   logic [3:0]  digit_sel;
   logic        clear;
   logic [15:0] value;
   logic [3:0]  valid;
   logic [3:0]  err;
   logic        update;
   logic [1:0]  upd_idx;
   logic        sel_err;

   int vec_cnt  = 0;
   int miss_cnt = 0;

   localparam logic [6:0] P_1   = 7'h79;
   localparam logic [6:0] P_2   = 7'h24;
   localparam logic [6:0] P_3   = 7'h30;
   localparam logic [6:0] P_5   = 7'h12;
   localparam logic [6:0] P_7   = 7'h78;
   localparam logic [6:0] P_8   = 7'h00;
   localparam logic [6:0] P_F   = 7'h0E;
   localparam logic [6:0] P_BAD = 7'h76;

   seg_capture #(
      .NUM_DIGITS   (4),
      .STABLE_COUNT (3),
      .CNT_W        (4)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .sample_en (sample_en),
      .seg_in    (seg_in),
      .digit_sel (digit_sel),
      .clear     (clear),
      .value     (value),
      .valid     (valid),
      .err       (err),
      .update    (update),
      .upd_idx   (upd_idx),
      .sel_err   (sel_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One sample_en strobe; returns on the falling edge after the capturing edge
   task automatic strobe(input logic [3:0] sel, input logic [6:0] seg);
      @(negedge clk);
      sample_en = 1'b1;
      digit_sel = sel;
      seg_in    = seg;
      @(negedge clk);
      sample_en = 1'b0;
      digit_sel = 4'hF;
      seg_in    = 7'h7F;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      sample_en = 1'b0; clear = 1'b0; digit_sel = 4'hF; seg_in = 7'h7F;
      repeat (2) @(negedge clk);
      vec_cnt++;
      if ({value, valid, err, update, upd_idx, sel_err} !== 29'd0) begin
         miss_cnt++;
         $display("FAIL reset_state: got %h required 0", {value, valid, err, update, upd_idx, sel_err});
      end
      rst_n = 1'b1;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         vec_cnt++;
         if ({value, valid, err, update, upd_idx, sel_err} !== 29'd0) begin
            miss_cnt++;
            $display("FAIL idle_cycle%0d: got %h required 0", c, {value, valid, err, update, upd_idx, sel_err});
         end
      end
   endtask

   task automatic test_commit;
      for (int k = 1; k <= 5; k++) begin
         strobe(4'b1110, P_2);
         vec_cnt++;
         if (k == 3) begin
            if (update !== 1'b1 || upd_idx !== 2'd0 || value !== 16'h0002 || valid !== 4'b0001) begin
               miss_cnt++;
               $display("FAIL commit_d0: got upd=%b idx=%0d val=%h vld=%b required upd=1 idx=0 val=0002 vld=0001",
                        update, upd_idx, value, valid);
            end
         end else if (update !== 1'b0) begin
            miss_cnt++;
            $display("FAIL commit_d0_nopulse%0d: got update=%b required 0", k, update);
         end
      end
      @(negedge clk);
      vec_cnt++;
      if (update !== 1'b0 || value !== 16'h0002) begin
         miss_cnt++;
         $display("FAIL commit_d0_hold: got upd=%b val=%h required upd=0 val=0002", update, value);
      end
   endtask

   task automatic test_ghosting;
      logic [6:0] seq [5];
      seq[0] = P_7; seq[1] = P_7; seq[2] = P_8; seq[3] = P_8; seq[4] = P_8;
      for (int k = 0; k < 5; k++) begin
         strobe(4'b1101, seq[k]);
         vec_cnt++;
         if (k == 4) begin
            if (update !== 1'b1 || upd_idx !== 2'd1 || value !== 16'h0082 || valid !== 4'b0011) begin
               miss_cnt++;
               $display("FAIL ghost_d1: got upd=%b idx=%0d val=%h vld=%b required upd=1 idx=1 val=0082 vld=0011",
                        update, upd_idx, value, valid);
            end
         end else if (update !== 1'b0) begin
            miss_cnt++;
            $display("FAIL ghost_early%0d: got update=%b required 0", k, update);
         end
      end
   endtask

   task automatic test_illegal;
      repeat (3) strobe(4'b1011, P_BAD);
      vec_cnt++;
      if (update !== 1'b1 || upd_idx !== 2'd2 || err !== 4'b0100 || valid !== 4'b0011 || value !== 16'h0082) begin
         miss_cnt++;
         $display("FAIL illegal_d2: got upd=%b idx=%0d err=%b vld=%b val=%h required 1 2 0100 0011 0082",
                  update, upd_idx, err, valid, value);
      end
      repeat (3) strobe(4'b1011, P_F);
      vec_cnt++;
      if (update !== 1'b1 || err !== 4'b0000 || valid !== 4'b0111 || value !== 16'h0F82) begin
         miss_cnt++;
         $display("FAIL recover_d2: got upd=%b err=%b vld=%b val=%h required 1 0000 0111 0F82",
                  update, err, valid, value);
      end
   endtask

   task automatic test_sel_err;
      logic [3:0] bad [3];
      bad[0] = 4'b1100; bad[1] = 4'b1111; bad[2] = 4'b0011;
      strobe(4'b0111, P_3);
      for (int k = 0; k < 3; k++) begin
         strobe(bad[k], P_3);
         vec_cnt++;
         if (sel_err !== 1'b1 || update !== 1'b0) begin
            miss_cnt++;
            $display("FAIL sel_err_pulse%0d: got sel_err=%b upd=%b required 1 0", k, sel_err, update);
         end
      end
      @(negedge clk);
      vec_cnt++;
      if (sel_err !== 1'b0) begin
         miss_cnt++;
         $display("FAIL sel_err_drop: got %b required 0", sel_err);
      end
      strobe(4'b0111, P_3);
      vec_cnt++;
      if (update !== 1'b0) begin
         miss_cnt++;
         $display("FAIL sel_err_no_advance: got update=%b required 0", update);
      end
      strobe(4'b0111, P_3);
      vec_cnt++;
      if (update !== 1'b1 || upd_idx !== 2'd3 || value !== 16'h3F82 || valid !== 4'b1111) begin
         miss_cnt++;
         $display("FAIL sel_err_then_d3: got upd=%b idx=%0d val=%h vld=%b required 1 3 3F82 1111",
                  update, upd_idx, value, valid);
      end
   endtask

   task automatic test_reset_mid;
      repeat (2) strobe(4'b1110, P_5);
      #2;
      rst_n = 1'b0;
      #1;
      vec_cnt++;
      if (value !== 16'h0000 || valid !== 4'b0000 || err !== 4'b0000) begin
         miss_cnt++;
         $display("FAIL async_reset: got val=%h vld=%b err=%b required 0000 0000 0000", value, valid, err);
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         strobe(4'b1110, P_5);
         vec_cnt++;
         if (k < 3 && update !== 1'b0) begin
            miss_cnt++;
            $display("FAIL post_reset_early%0d: got update=%b required 0", k, update);
         end else if (k == 3 && (update !== 1'b1 || value !== 16'h0005 || valid !== 4'b0001)) begin
            miss_cnt++;
            $display("FAIL post_reset_commit: got upd=%b val=%h vld=%b required 1 0005 0001", update, value, valid);
         end
      end
   endtask

   task automatic test_clear;
      repeat (3) strobe(4'b1011, P_BAD);
      repeat (2) strobe(4'b1101, P_1);
      vec_cnt++;
      if (err !== 4'b0100 || update !== 1'b0) begin
         miss_cnt++;
         $display("FAIL pre_clear: got err=%b upd=%b required 0100 0", err, update);
      end
      @(negedge clk);
      clear = 1'b1; sample_en = 1'b1; digit_sel = 4'b1101; seg_in = P_1;
      @(negedge clk);
      clear = 1'b0; sample_en = 1'b0; digit_sel = 4'hF; seg_in = 7'h7F;
      vec_cnt++;
      if (update !== 1'b0 || valid !== 4'b0000 || err !== 4'b0000 || value !== 16'h0005 || sel_err !== 1'b0) begin
         miss_cnt++;
         $display("FAIL clear_with_sample: got upd=%b vld=%b err=%b val=%h se=%b required 0 0000 0000 0005 0",
                  update, valid, err, value, sel_err);
      end
      for (int k = 1; k <= 3; k++) begin
         strobe(4'b1101, P_1);
         vec_cnt++;
         if (k < 3 && update !== 1'b0) begin
            miss_cnt++;
            $display("FAIL post_clear_early%0d: got update=%b required 0", k, update);
         end else if (k == 3 && (update !== 1'b1 || upd_idx !== 2'd1 || value !== 16'h0015 || valid !== 4'b0010)) begin
            miss_cnt++;
            $display("FAIL post_clear_commit: got upd=%b idx=%0d val=%h vld=%b required 1 1 0015 0010",
                     update, upd_idx, value, valid);
         end
      end
   endtask

   initial begin
      test_reset();
      test_commit();
      test_ghosting();
      test_illegal();
      test_sel_err();
      test_reset_mid();
      test_clear();
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
      $finish;
   end

endmodule

`default_nettype wire
